// File: rtl/wqe_dispatcher_if.sv
// Work-queue FIFO pop side, DCS Avalon-MM write port and completion/status signals.
interface wqe_dispatcher_if;
    logic         enable;
    logic [111:0] fifoData;
    logic         fifoEmpty;
    logic         fifoPop;
    logic [7:0]   dcsAddress;
    logic [31:0]  dcsWriteData;
    logic [3:0]   dcsByteEnable;
    logic         dcsWrite;
    logic         rdDcsChipSelect;
    logic         wrDcsChipSelect;
    logic         rdDcsWaitRequest;
    logic         wrDcsWaitRequest;
    logic         cmplValid;
    logic [7:0]   cmplTid;
    logic [4:0]   cmplOpcode;
    logic         busy;
    logic [7:0]   errCount;

    modport master (
        input  enable, fifoData, fifoEmpty, rdDcsWaitRequest, wrDcsWaitRequest,
        output fifoPop, dcsAddress, dcsWriteData, dcsByteEnable, dcsWrite,
               rdDcsChipSelect, wrDcsChipSelect, cmplValid, cmplTid, cmplOpcode,
               busy, errCount
    );

    modport slave (
        output enable, fifoData, fifoEmpty, rdDcsWaitRequest, wrDcsWaitRequest,
        input  fifoPop, dcsAddress, dcsWriteData, dcsByteEnable, dcsWrite,
               rdDcsChipSelect, wrDcsChipSelect, cmplValid, cmplTid, cmplOpcode,
               busy, errCount
    );
endinterface

// File: rtl/wqe_dispatcher.sv
// Unpacks one 112-bit WQE into four DCS writes (last one is the doorbell); 7 cycles/WQE, 3 on error.
// Each write holds while the selected waitrequest is high; no new pop while busy or enable is low.
module wqe_dispatcher (
    input  logic               clock,
    input  logic               reset,
    wqe_dispatcher_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WR0, S_WR1, S_WR2, S_WR3, S_DONE, S_ERR
    } state_e;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  data_num;
        logic [7:0]  len0;
        logic [7:0]  len1;
        logic [7:0]  len2;
        logic [7:0]  len3;
        logic [7:0]  tid;
        logic [63:0] desc_addr;
    } wqe_t;

    state_e      state_q, state_d;
    wqe_t        wqe_q, wqe_d;
    logic [7:0]  dcs_address_q, dcs_address_d;
    logic [31:0] dcs_wdata_q, dcs_wdata_d;
    logic [3:0]  dcs_be_q, dcs_be_d;
    logic        dcs_write_q, dcs_write_d;
    logic        rd_cs_q, rd_cs_d;
    logic        wr_cs_q, wr_cs_d;
    logic        cmpl_vld_q, cmpl_vld_d;
    logic [7:0]  cmpl_tid_q, cmpl_tid_d;
    logic [4:0]  cmpl_opcode_q, cmpl_opcode_d;
    logic        busy_q, busy_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        pop;
    logic        sel_rd, sel_wr, wqe_ok, wait_sel;
    logic [9:0]  total_len;

    // Reset gates the pop so no entry is consumed while the block is held in reset.
    assign pop      = reset && (state_q == S_IDLE) && bus.enable && !bus.fifoEmpty;
    assign sel_rd   = (wqe_q.opcode == 5'h01);
    assign sel_wr   = (wqe_q.opcode == 5'h02);
    assign wqe_ok   = (sel_rd || sel_wr) && (wqe_q.data_num != 3'd0) && (wqe_q.data_num <= 3'd4);
    assign wait_sel = sel_rd ? bus.rdDcsWaitRequest : bus.wrDcsWaitRequest;

    always_comb begin
        total_len = 10'd0;
        if (wqe_q.data_num >= 3'd1) total_len = total_len + {2'b00, wqe_q.len0};
        if (wqe_q.data_num >= 3'd2) total_len = total_len + {2'b00, wqe_q.len1};
        if (wqe_q.data_num >= 3'd3) total_len = total_len + {2'b00, wqe_q.len2};
        if (wqe_q.data_num >= 3'd4) total_len = total_len + {2'b00, wqe_q.len3};
    end

    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        wqe_d   = wqe_q;
        case (state_q)
            S_IDLE:  if (pop) begin
                         wqe_d   = wqe_t'(bus.fifoData);
                         state_d = S_CHECK;
                     end
            S_CHECK: state_d = wqe_ok ? S_WR0 : S_ERR;
            S_WR0:   if (!wait_sel) state_d = S_WR1;
            S_WR1:   if (!wait_sel) state_d = S_WR2;
            S_WR2:   if (!wait_sel) state_d = S_WR3;
            S_WR3:   if (!wait_sel) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        dcs_address_d = 8'h00;
        dcs_wdata_d   = 32'h0;
        dcs_write_d   = 1'b0;
        cmpl_vld_d    = 1'b0;
        cmpl_tid_d    = cmpl_tid_q;
        cmpl_opcode_d = cmpl_opcode_q;
        err_cnt_d     = err_cnt_q;
        case (state_d)
            S_WR0: begin
                dcs_write_d = 1'b1;
                dcs_wdata_d = wqe_q.desc_addr[31:0];
            end
            S_WR1: begin
                dcs_write_d   = 1'b1;
                dcs_address_d = 8'h04;
                dcs_wdata_d   = wqe_q.desc_addr[63:32];
            end
            S_WR2: begin
                dcs_write_d   = 1'b1;
                dcs_address_d = 8'h08;
                dcs_wdata_d   = {wqe_q.tid, 5'd0, wqe_q.data_num, 6'd0, total_len};
            end
            S_WR3: begin
                dcs_write_d   = 1'b1;
                dcs_address_d = 8'h0C;
                dcs_wdata_d   = {27'd0, wqe_q.opcode};
            end
            S_DONE: begin
                cmpl_vld_d    = 1'b1;
                cmpl_tid_d    = wqe_q.tid;
                cmpl_opcode_d = wqe_q.opcode;
            end
            default: ;
        endcase
        dcs_be_d = dcs_write_d ? 4'hF : 4'h0;
        rd_cs_d  = dcs_write_d && sel_rd;
        wr_cs_d  = dcs_write_d && sel_wr;
        busy_d   = (state_d != S_IDLE);
        if (state_q == S_ERR && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wqe_q         <= '0;
            dcs_address_q <= 8'h00;
            dcs_wdata_q   <= 32'h0;
            dcs_be_q      <= 4'h0;
            dcs_write_q   <= 1'b0;
            rd_cs_q       <= 1'b0;
            wr_cs_q       <= 1'b0;
            cmpl_vld_q    <= 1'b0;
            cmpl_tid_q    <= 8'h00;
            cmpl_opcode_q <= 5'h00;
            busy_q        <= 1'b0;
            err_cnt_q     <= 8'h00;
        end else begin
            wqe_q         <= wqe_d;
            dcs_address_q <= dcs_address_d;
            dcs_wdata_q   <= dcs_wdata_d;
            dcs_be_q      <= dcs_be_d;
            dcs_write_q   <= dcs_write_d;
            rd_cs_q       <= rd_cs_d;
            wr_cs_q       <= wr_cs_d;
            cmpl_vld_q    <= cmpl_vld_d;
            cmpl_tid_q    <= cmpl_tid_d;
            cmpl_opcode_q <= cmpl_opcode_d;
            busy_q        <= busy_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign bus.fifoPop         = pop;
    assign bus.dcsAddress      = dcs_address_q;
    assign bus.dcsWriteData    = dcs_wdata_q;
    assign bus.dcsByteEnable   = dcs_be_q;
    assign bus.dcsWrite        = dcs_write_q;
    assign bus.rdDcsChipSelect = rd_cs_q;
    assign bus.wrDcsChipSelect = wr_cs_q;
    assign bus.cmplValid       = cmpl_vld_q;
    assign bus.cmplTid         = cmpl_tid_q;
    assign bus.cmplOpcode      = cmpl_opcode_q;
    assign bus.busy            = busy_q;
    assign bus.errCount        = err_cnt_q;

endmodule

// File: tb/tb_wqe_dispatcher.sv
// Directed bench for wqe_dispatcher: table of WQEs with hand-computed DCS words plus timing sequences.
module tb_wqe_dispatcher;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    wqe_dispatcher_if bus();
    wqe_dispatcher dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        logic [111:0]     wqe;
        bit               is_err;
        bit               is_rd;
        logic [3:0][31:0] w;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        bit          acc;
    } wr_rec_t;

    typedef struct {
        int         cyc;
        logic [7:0] tid;
        logic [4:0] opc;
    } cmpl_rec_t;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int pop_total = 0;
    int rd_cs_cycles = 0;
    int both_cs = 0;
    int wr_ptr = 0;
    int exp_err = 0;
    logic [111:0] fifo_mem [0:1023];
    int        pop_log [$];
    wr_rec_t   wr_log [$];
    cmpl_rec_t cmpl_log [$];
    wr_rec_t   acc_q [$];
    vec_t      tbl [8];

    // Monitor: everything is sampled on the falling edge.
    always @(negedge clock) begin
        wr_rec_t r;
        if (bus.fifoPop) begin
            pop_log.push_back(cyc);
            pop_total++;
        end
        if (bus.dcsWrite) begin
            r.cyc  = cyc;
            r.addr = bus.dcsAddress;
            r.data = bus.dcsWriteData;
            r.rd   = bus.rdDcsChipSelect;
            r.wr   = bus.wrDcsChipSelect;
            r.be   = bus.dcsByteEnable;
            r.acc  = bus.rdDcsChipSelect ? !bus.rdDcsWaitRequest : !bus.wrDcsWaitRequest;
            wr_log.push_back(r);
        end
        if (bus.cmplValid) cmpl_log.push_back('{cyc, bus.cmplTid, bus.cmplOpcode});
        if (bus.rdDcsChipSelect) rd_cs_cycles++;
        if (bus.rdDcsChipSelect && bus.wrDcsChipSelect) both_cs++;
    end

    // Show-ahead FIFO model, refreshed just after each rising edge.
    initial begin
        bus.fifoEmpty = 1'b1;
        bus.fifoData  = '0;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            bus.fifoEmpty = (pop_total == wr_ptr);
            bus.fifoData  = fifo_mem[pop_total];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [111:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        bit done = 0;
        while (!done) begin
            @(negedge clock);
            n++;
            if (pop_total == wr_ptr && !bus.busy && !bus.fifoPop) done = 1;
            else if (n > max) begin
                chk("wait_idle_timeout", 64'd1, 64'd0);
                done = 1;
            end
        end
    endtask

    task automatic wait_write_addr(input logic [7:0] a);
        int n = 0;
        bit done = 0;
        while (!done) begin
            @(negedge clock);
            n++;
            if (bus.dcsWrite && bus.dcsAddress == a) done = 1;
            else if (n > 50) begin
                chk("wait_write_timeout", 64'd1, 64'd0);
                done = 1;
            end
        end
    endtask

    task automatic collect(input int base);
        acc_q = {};
        for (int k = base; k < wr_log.size(); k++)
            if (wr_log[k].acc) acc_q.push_back(wr_log[k]);
    endtask

    task automatic check_desc(input vec_t v, input int bw, input int bp, input int bc, input int lat);
        collect(bw);
        chk("write_count", acc_q.size(), 4);
        for (int k = 0; k < 4 && k < acc_q.size(); k++) begin
            chk("addr", acc_q[k].addr, k * 4);
            chk("data", acc_q[k].data, v.w[k]);
            chk("chipsel", {acc_q[k].rd, acc_q[k].wr}, v.is_rd ? 2'b10 : 2'b01);
            chk("byteen", acc_q[k].be, 4'hF);
        end
        chk("cmpl_count", cmpl_log.size() - bc, 1);
        if (cmpl_log.size() > bc && pop_log.size() > bp) begin
            chk("cmpl_latency", cmpl_log[bc].cyc - pop_log[bp], lat);
            chk("cmpl_tid", cmpl_log[bc].tid, v.wqe[71:64]);
            chk("cmpl_opcode", cmpl_log[bc].opc, v.wqe[111:107]);
        end
    endtask

    function automatic vec_t mkv(input logic [111:0] wqe, input bit err, input bit rd,
                                 input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [31:0] w2, input logic [31:0] w3);
        vec_t v;
        v.wqe = wqe; v.is_err = err; v.is_rd = rd;
        v.w = {w3, w2, w1, w0};
        return v;
    endfunction

    function automatic int sat_inc(input int e);
        return (e >= 255) ? 255 : e + 1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int bw, bp, bc, hold_cnt, match_cnt, rd0;
        bus.enable = 1'b0;
        bus.rdDcsWaitRequest = 1'b0;
        bus.wrDcsWaitRequest = 1'b0;

        tbl[0] = mkv({5'h01, 3'd2, 8'h10, 8'h20, 8'h77, 8'h88, 8'h5A, 64'h0001_2345_6789_ABCD},
                     0, 1, 32'h6789ABCD, 32'h00012345, 32'h5A020030, 32'h00000001);
        tbl[1] = mkv({5'h02, 3'd4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h33, 64'hFEDC_BA98_7654_3210},
                     0, 0, 32'h76543210, 32'hFEDCBA98, 32'h330403FC, 32'h00000002);
        tbl[2] = mkv({5'h01, 3'd1, 8'hAB, 8'h11, 8'h11, 8'h11, 8'h01, 64'h0000_0000_FFFF_0000},
                     0, 1, 32'hFFFF0000, 32'h00000000, 32'h010100AB, 32'h00000001);
        tbl[3] = mkv({5'h02, 3'd3, 8'h01, 8'h02, 8'h03, 8'h40, 8'hC3, 64'h8000_0000_0000_0001},
                     0, 0, 32'h00000001, 32'h80000000, 32'hC3030006, 32'h00000002);
        tbl[4] = mkv({5'h07, 3'd2, 8'h10, 8'h20, 8'h00, 8'h00, 8'h11, 64'h1}, 1, 0, 0, 0, 0, 0);
        tbl[5] = mkv({5'h01, 3'd0, 8'h10, 8'h20, 8'h00, 8'h00, 8'h12, 64'h2}, 1, 0, 0, 0, 0, 0);
        tbl[6] = mkv({5'h02, 3'd5, 8'h10, 8'h20, 8'h00, 8'h00, 8'h13, 64'h3}, 1, 0, 0, 0, 0, 0);
        tbl[7] = mkv({5'h00, 3'd1, 8'h10, 8'h20, 8'h00, 8'h00, 8'h14, 64'h4}, 1, 0, 0, 0, 0, 0);

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_fifoPop", bus.fifoPop, 0);
        chk("rst_dcsWrite", bus.dcsWrite, 0);
        chk("rst_rdcs", bus.rdDcsChipSelect, 0);
        chk("rst_wrcs", bus.wrDcsChipSelect, 0);
        chk("rst_addr", bus.dcsAddress, 0);
        chk("rst_data", bus.dcsWriteData, 0);
        chk("rst_be", bus.dcsByteEnable, 0);
        chk("rst_cmplValid", bus.cmplValid, 0);
        chk("rst_cmplTid", bus.cmplTid, 0);
        chk("rst_cmplOpcode", bus.cmplOpcode, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_errCount", bus.errCount, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        bus.enable = 1'b1;

        // Table: the unselected target's waitrequest is held high and must be ignored.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            bus.rdDcsWaitRequest = !tbl[i].is_rd;
            bus.wrDcsWaitRequest = tbl[i].is_rd || tbl[i].is_err;
            bw = wr_log.size(); bp = pop_log.size(); bc = cmpl_log.size();
            push(tbl[i].wqe);
            wait_idle(60);
            chk("vec_pops", pop_log.size() - bp, 1);
            if (tbl[i].is_err) begin
                exp_err = sat_inc(exp_err);
                chk("err_no_write", wr_log.size() - bw, 0);
                chk("err_no_cmpl", cmpl_log.size() - bc, 0);
                chk("err_count", bus.errCount, exp_err);
            end else begin
                check_desc(tbl[i], bw, bp, bc, 6);
                chk("ok_errcount_hold", bus.errCount, exp_err);
            end
        end
        bus.rdDcsWaitRequest = 1'b0;
        bus.wrDcsWaitRequest = 1'b0;

        // Back-to-back error WQEs: pop every 3 cycles.
        bp = pop_log.size();
        push(tbl[4].wqe); push(tbl[6].wqe);
        wait_idle(40);
        exp_err = sat_inc(sat_inc(exp_err));
        chk("err_pops", pop_log.size() - bp, 2);
        if (pop_log.size() >= bp + 2) chk("err_pop_gap", pop_log[bp+1] - pop_log[bp], 3);
        chk("err_count_b2b", bus.errCount, exp_err);

        // Write WQE stalled 3 cycles on WR1; read waitrequest high but ignored.
        bus.rdDcsWaitRequest = 1'b1;
        bw = wr_log.size(); bp = pop_log.size(); bc = cmpl_log.size(); rd0 = rd_cs_cycles;
        push(tbl[1].wqe);
        wait_write_addr(8'h00);
        @(posedge clock); #1;
        bus.wrDcsWaitRequest = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        bus.wrDcsWaitRequest = 1'b0;
        wait_idle(60);
        bus.rdDcsWaitRequest = 1'b0;
        check_desc(tbl[1], bw, bp, bc, 9);
        hold_cnt = 0; match_cnt = 0;
        for (int k = bw; k < wr_log.size(); k++)
            if (wr_log[k].addr == 8'h04) begin
                hold_cnt++;
                if (wr_log[k].data == tbl[1].w[1] && wr_log[k].wr && wr_log[k].be == 4'hF) match_cnt++;
            end
        chk("stall_hold_cycles", hold_cnt, 4);
        chk("stall_stable", match_cnt, 4);
        chk("stall_no_rdcs", rd_cs_cycles - rd0, 0);

        // Three valid WQEs back to back.
        bw = wr_log.size(); bp = pop_log.size(); bc = cmpl_log.size();
        push(tbl[0].wqe); push(tbl[1].wqe); push(tbl[2].wqe);
        wait_idle(100);
        chk("b2b_pops", pop_log.size() - bp, 3);
        if (pop_log.size() >= bp + 3) begin
            chk("b2b_pop1", pop_log[bp+1] - pop_log[bp], 7);
            chk("b2b_pop2", pop_log[bp+2] - pop_log[bp], 14);
        end
        collect(bw);
        chk("b2b_writes", acc_q.size(), 12);
        chk("b2b_cmpls", cmpl_log.size() - bc, 3);
        if (cmpl_log.size() >= bc + 3) begin
            chk("b2b_tid0", cmpl_log[bc].tid, 8'h5A);
            chk("b2b_tid1", cmpl_log[bc+1].tid, 8'h33);
            chk("b2b_tid2", cmpl_log[bc+2].tid, 8'h01);
        end

        // enable low blocks pops; dropping it during WR1 lets the current WQE finish.
        bus.enable = 1'b0;
        bp = pop_log.size(); bc = cmpl_log.size();
        push(tbl[2].wqe);
        repeat (10) @(negedge clock);
        chk("dis_no_pop", pop_log.size() - bp, 0);
        chk("dis_busy", bus.busy, 0);
        push(tbl[0].wqe);
        bus.enable = 1'b1;
        wait_write_addr(8'h04);
        #1 bus.enable = 1'b0;
        repeat (20) @(negedge clock);
        chk("drop_pops", pop_log.size() - bp, 1);
        chk("drop_cmpls", cmpl_log.size() - bc, 1);
        if (cmpl_log.size() > bc) chk("drop_tid", cmpl_log[bc].tid, 8'h01);
        chk("drop_busy", bus.busy, 0);
        bus.enable = 1'b1;
        wait_idle(40);
        chk("resume_pops", pop_log.size() - bp, 2);
        if (cmpl_log.size() > bc + 1) chk("resume_tid", cmpl_log[bc+1].tid, 8'h5A);

        // Reset during WR2 abandons the WQE; the next entry then dispatches normally.
        push(tbl[0].wqe); push(tbl[3].wqe);
        wait_write_addr(8'h08);
        #1 reset = 1'b0;
        @(negedge clock);
        exp_err = 0;
        chk("midrst_dcsWrite", bus.dcsWrite, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_rdcs", bus.rdDcsChipSelect, 0);
        chk("midrst_addr", bus.dcsAddress, 0);
        chk("midrst_errCount", bus.errCount, 0);
        bw = wr_log.size(); bp = pop_log.size(); bc = cmpl_log.size();
        @(posedge clock); #1;
        reset = 1'b1;
        wait_idle(40);
        chk("post_rst_pops", pop_log.size() - bp, 1);
        check_desc(tbl[3], bw, bp, bc, 6);

        // errCount saturation.
        for (int k = 0; k < 254; k++) begin
            push(tbl[5].wqe);
            exp_err = sat_inc(exp_err);
        end
        wait_idle(2000);
        chk("sat_fe", bus.errCount, exp_err);
        push(tbl[6].wqe);
        exp_err = sat_inc(exp_err);
        wait_idle(40);
        chk("sat_ff", bus.errCount, exp_err);
        for (int k = 0; k < 3; k++) begin
            push(tbl[7].wqe);
            exp_err = sat_inc(exp_err);
        end
        wait_idle(60);
        chk("sat_hold", bus.errCount, 8'hFF);
        chk("sat_model", exp_err, bus.errCount);

        chk("one_chipsel", both_cs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/wqe_dispatcher.md
# wqe_dispatcher

Pop-side consumer of a work-queue FIFO (send or receive queue). Takes each 112-bit work-queue entry (WQE) built by the host-facing slot writes and unpacks it. It then replays the entry as four 32-bit Avalon-MM writes into the DMA descriptor-controller slave (read engine or write engine), with the last write acting as the doorbell. One instance sits between each queue FIFO and the DMA descriptor-controller ports.

## Interface
- No parameters; widths fixed by the WQE format.
- clock  in  1  single clock domain.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  when low, no new WQE is popped; an in-flight WQE completes.
- fifoData  in  112  WQE at FIFO head, valid while fifoEmpty=0 (show-ahead).
- fifoEmpty  in  1  FIFO empty flag.
- fifoPop  out  1  one-cycle pop strobe; consumes the head entry.
- dcsAddress  out  8  Avalon byte address (0x00/0x04/0x08/0x0C).
- dcsWriteData  out  32  Avalon write data.
- dcsByteEnable  out  4  4'hF during a write, 4'h0 otherwise.
- dcsWrite  out  1  Avalon write.
- rdDcsChipSelect  out  1  targets the read-DMA descriptor controller.
- wrDcsChipSelect  out  1  targets the write-DMA descriptor controller.
- rdDcsWaitRequest  in  1  waitrequest from the read DCS.
- wrDcsWaitRequest  in  1  waitrequest from the write DCS.
- cmplValid  out  1  one-cycle pulse after the doorbell is accepted.
- cmplTid  out  8  TID of the completed dispatch; valid with cmplValid.
- cmplOpcode  out  5  opcode of the completed dispatch; valid with cmplValid.
- busy  out  1  high in every state except IDLE.
- errCount  out  8  saturating count of discarded WQEs.

## Operation
- WQE fields:
  - [111:107] opcode, [106:104] dataNum.
  - [103:96] len0, [95:88] len1, [87:80] len2, [79:72] len3.
  - [71:64] TID.
  - [63:0] descTableAddr = {hi[63:48], me[47:16], lo[15:0]}, used as one 64-bit address.
- Opcode 5'h01 selects the read DCS; 5'h02 selects the write DCS. Any other opcode is an error.
- dataNum must be 1..4, otherwise the WQE is an error. totalLen = zero-extended sum of len0..len(dataNum-1), 10-bit result in a 16-bit field.
- Error WQE: popped and discarded, no bus activity, no cmplValid, errCount+1 (saturates at 8'hFF).
- Words written, in order:
  - 0x00: descTableAddr[31:0].
  - 0x04: descTableAddr[63:32].
  - 0x08: {TID, 5'd0, dataNum, totalLen}.
  - 0x0C: {27'd0, opcode}; this is the doorbell.
- FSM states and transitions:
  - IDLE: when enable & !fifoEmpty, assert fifoPop combinationally and latch fifoData on the same edge, then go to CHECK.
  - CHECK: compute target and totalLen; go to ERR if invalid, else WR0.
  - WR0..WR3: assert dcsWrite, the selected chipselect, and dcsAddress/dcsWriteData. Advance on a clock edge where the selected waitrequest is 0.
  - DONE: cmplValid=1 for one cycle, then IDLE.
  - ERR: increment errCount, then IDLE.
- Only one chipselect is ever high at a time. The unselected target's waitrequest is ignored.

## Timing
- Reset values: fifoPop=0, dcsWrite=0, both chipselects=0, dcsAddress=0, dcsWriteData=0, dcsByteEnable=0, cmplValid=0, cmplTid=0, cmplOpcode=0, busy=0, errCount=0; state=IDLE.
- Pop in cycle N (IDLE). CHECK in N+1. WR0 in N+2.
- With waitrequest=0 throughout, the doorbell is accepted at the end of N+5 and cmplValid is high in N+6. Minimum 7 cycles per WQE; the next pop is earliest at N+7.
- Error path: pop at N, CHECK at N+1, ERR at N+2, errCount updated at the end of N+2, next pop earliest at N+3.
- While waitrequest=1, address, data, byteenable, write and chipselect hold stable. There is no timeout.
- All outputs are registered except fifoPop.
- enable dropping mid-dispatch has no effect until the return to IDLE.
- reset low mid-dispatch: all outputs return to reset values on the next edge and the current WQE is abandoned. The DCS may have seen a partial descriptor without a doorbell. errCount clears.
- fifoEmpty asserted while not in IDLE is ignored.

## Test plan
- Single valid read WQE. Opcode 01, dataNum 2, len0=0x10, len1=0x20, TID=0x5A, addr=0x0001_2345_6789_ABCD, waitrequest=0.
  - Required response: 4 rdDcs writes with data 0x6789ABCD, 0x00012345, 0x5A020030, 0x00000001.
  - cmplValid at N+6 with cmplTid=0x5A.
- Write WQE, opcode 02, with wrDcsWaitRequest held high for 3 cycles on WR1 -> address 0x04 and data held stable for 4 cycles; rdDcsChipSelect never asserts; cmplValid at N+9.
- Invalid WQEs: opcode 0x07, then dataNum 0, then dataNum 5 -> each is popped with no dcsWrite activity; errCount=3.
  - 256 errors -> errCount saturates at 0xFF.
- Back-to-back FIFO of 3 valid WQEs -> pops at N, N+7, N+14; exactly 12 writes; 3 cmplValid pulses in TID order.
- reset low during WR2 -> next cycle dcsWrite=0 and busy=0; after release, the next FIFO entry dispatches normally.
- enable=0 with a non-empty FIFO -> no pop.
  - Dropping enable during WR1 -> the current WQE completes and no further pop follows.
